hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage core. It is the producer side of the ID/EX buffer's `stall` input: it decides each cycle whether the IF, IF/ID, ID/EX and EX/MEM registers advance, hold, or receive a bubble. It sits beside the decode stage and covers three cases:
- load-use data hazards (one-cycle bubble);
- fixed-latency multi-cycle data-memory accesses (counter-driven freeze);
- branch-redirect flushes from EX.

## Interface
Parameters:
- `REG_W`, default 4: register-index width.
- `DMEM_LAT`, default 4: cycles a load/store occupies MEM. Legal range 1..16.

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  synchronous, active-low reset
- `srcA_ID`  in  REG_W  first source register index of the instruction in ID
- `srcAUsed_ID`  in  1  instruction in ID reads `srcA_ID`
- `srcB_ID`  in  REG_W  second source register index of the instruction in ID
- `srcBUsed_ID`  in  1  instruction in ID reads `srcB_ID`
- `destReg_EX`  in  REG_W  destination register of the instruction in EX
- `writeReg_EX`  in  1  instruction in EX writes the register file
- `memRead_EX`  in  1  instruction in EX is a load
- `memAccess_MEM`  in  1  valid load/store present in MEM this cycle
- `flush`  in  1  branch/jump redirect resolved in EX
- `stall_IF`  out  1  hold PC and IF/ID
- `stall_ID_EX`  out  1  hold ID/EX; drives the ID/EX buffer `stall` input
- `bubble_ID_EX`  out  1  load ID/EX with a NOP (control bits cleared)
- `flush_IF_ID`  out  1  load IF/ID with a NOP
- `stall_EX_MEM`  out  1  hold EX/MEM and MEM/WB
- `stallCycles`  out  16  stall-cycle counter; present only with `HAZARD_STALL_CNT_EN`

## Operation
**FSM states:** RUN and MEM_WAIT. A 4-bit down-counter `cnt` is associated with MEM_WAIT.

**memStall** is asserted in either of these conditions:
- state RUN, `memAccess_MEM` = 1 and DMEM_LAT ≥ 2;
- state MEM_WAIT with `cnt` ≠ 0.

**Transitions:**
- RUN → MEM_WAIT on `memAccess_MEM` = 1 when DMEM_LAT ≥ 2; `cnt` loads DMEM_LAT−2.
- In MEM_WAIT, while `cnt` ≠ 0: decrement `cnt`.
- In MEM_WAIT, when `cnt` = 0 (release cycle): no memStall; next state RUN.
- DMEM_LAT = 1: the FSM never leaves RUN and memStall is never asserted.

**Output priority (highest first):**
1. memStall: `stall_IF`, `stall_ID_EX` and `stall_EX_MEM` are all 1; `bubble_ID_EX` and `flush_IF_ID` are 0. Load-use and flush are ignored, because EX is frozen and re-presents them after release.
2. `flush`: `flush_IF_ID` = 1 and `bubble_ID_EX` = 1; all stall outputs are 0.
3. Load-use: `memRead_EX` & `writeReg_EX` & ((`srcAUsed_ID` & `srcA_ID` == `destReg_EX`) | (`srcBUsed_ID` & `srcB_ID` == `destReg_EX`)). Response: `stall_IF` = 1 and `bubble_ID_EX` = 1; all other outputs are 0. The hazard clears on the next cycle because EX then holds the bubble.
4. Otherwise all outputs are 0.

**Other rules:**
- The release cycle is evaluated as RUN for priorities 2–4.
- Register index 0 is not special; a matching index triggers a hazard.
- `stall_ID_EX` and `bubble_ID_EX` are never both 1.

## Timing
- The control outputs are combinational from the current state and inputs, and are valid in the same cycle. State and `cnt` update on the rising edge of `clk`.
- A memory access stalls the pipeline for DMEM_LAT−1 cycles, followed by one release cycle. With DMEM_LAT = 4, `stall_*` is high for 3 cycles.
- A memory access in MEM on the release cycle's successor starts a new wait immediately (back-to-back accesses).
- Reset: while `rst_n` = 0 at a clock edge, state ← RUN, `cnt` ← 0 and `stallCycles` ← 0.
  - While `rst_n` is low, all control outputs are forced to 0.
  - Reset during MEM_WAIT abandons the wait.

## Configuration
`HAZARD_STALL_CNT_EN`:
- **Defined:** `stallCycles` exists. It increments on each clock edge where `stall_IF` = 1 (any cause), saturates at 16'hFFFF, and resets to 0.
- **Undefined:** the port and its counter logic are absent. All other behaviour is identical.

## Test plan
- Load-use: `memRead_EX` = 1, `writeReg_EX` = 1, `destReg_EX` = 3, `srcA_ID` = 3, `srcAUsed_ID` = 1 → exactly one cycle with `stall_IF` = 1, `bubble_ID_EX` = 1, `stall_ID_EX` = 0. The same indices with `srcAUsed_ID` = 0 → no stall.
- Memory wait: DMEM_LAT = 4, `memAccess_MEM` pulsed at cycle 0 → `stall_IF`, `stall_ID_EX` and `stall_EX_MEM` are 1 for cycles 0–2 and 0 at cycle 3. With DMEM_LAT = 1 → no stall.
- Flush priority: `flush` = 1 together with an active load-use match → `flush_IF_ID` = 1, `bubble_ID_EX` = 1, `stall_IF` = 0.
- Mem wait dominates: `flush` = 1 during MEM_WAIT → only the stall outputs are 1. On the release cycle → the flush outputs are asserted.
- Reset mid-wait: `rst_n` low at cycle 1 of a DMEM_LAT = 8 wait → all outputs 0 and state RUN on the next cycle. With the macro defined, `stallCycles` = 0.
- Counter saturation (macro defined): force 70000 stall cycles → `stallCycles` = 16'hFFFF and holds.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage core: load-use bubbles, fixed-latency MEM freeze, EX redirect flush.
// Optional stall-cycle counter port (stallCycles) is built when HAZARD_STALL_CNT_EN is defined.
module hazard_ctrl #(
    parameter int REG_W    = 4,
    parameter int DMEM_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] srcA_ID,
    input  logic             srcAUsed_ID,
    input  logic [REG_W-1:0] srcB_ID,
    input  logic             srcBUsed_ID,
    input  logic [REG_W-1:0] destReg_EX,
    input  logic             writeReg_EX,
    input  logic             memRead_EX,
    input  logic             memAccess_MEM,
    input  logic             flush,
    output logic             stall_IF,
    output logic             stall_ID_EX,
    output logic             bubble_ID_EX,
    output logic             flush_IF_ID,
    output logic             stall_EX_MEM
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [15:0]      stallCycles
`endif
);

    typedef enum logic {
        S_RUN      = 1'b0,
        S_MEM_WAIT = 1'b1
    } state_t;

    // Single-cycle memory never freezes; the wait counter then stays idle.
    localparam bit         MULTI_CYC  = (DMEM_LAT >= 2);
    localparam int         CNT_INIT_I = MULTI_CYC ? (DMEM_LAT - 2) : 0;
    localparam logic [3:0] CNT_INIT   = CNT_INIT_I[3:0];

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_cnt;
    logic [3:0] w_next_cnt;
    logic       w_mem_stall;
    logic       w_load_use;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_mem_stall  = 1'b0;
        case (r_state)
            S_RUN: begin
                if (MULTI_CYC && memAccess_MEM) begin
                    w_mem_stall  = 1'b1;
                    w_next_state = S_MEM_WAIT;
                    w_next_cnt   = CNT_INIT;
                end
            end
            S_MEM_WAIT: begin
                // cnt == 0 is the release cycle: pipeline moves, then back to RUN.
                if (r_cnt != 4'd0) begin
                    w_mem_stall = 1'b1;
                    w_next_cnt  = r_cnt - 4'd1;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            default: begin
                w_next_state = S_RUN;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    assign w_load_use = memRead_EX & writeReg_EX &
                        ((srcAUsed_ID & (srcA_ID == destReg_EX)) |
                         (srcBUsed_ID & (srcB_ID == destReg_EX)));

    always_comb begin
        stall_IF     = 1'b0;
        stall_ID_EX  = 1'b0;
        bubble_ID_EX = 1'b0;
        flush_IF_ID  = 1'b0;
        stall_EX_MEM = 1'b0;
        if (rst_n) begin
            // A frozen EX re-presents any flush/load-use once the wait releases.
            if (w_mem_stall) begin
                stall_IF     = 1'b1;
                stall_ID_EX  = 1'b1;
                stall_EX_MEM = 1'b1;
            end else if (flush) begin
                flush_IF_ID  = 1'b1;
                bubble_ID_EX = 1'b1;
            end else if (w_load_use) begin
                stall_IF     = 1'b1;
                bubble_ID_EX = 1'b1;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= 16'd0;
        end else if (stall_IF && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stallCycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (DMEM_LAT 4, 1, 8) share ID/EX inputs.
// Counter checks are compiled in when HAZARD_STALL_CNT_EN is defined.
module tb_hazard_ctrl;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] LU   = 5'b10100;
    localparam logic [4:0] FL   = 5'b00110;
    localparam logic [4:0] MS   = 5'b11001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] srcA, srcB, dest;
    logic       aUsed, bUsed, wr, rd, fl;
    logic       m4, m1, m8;

    logic sif4, sidex4, bub4, fl4, sexm4;
    logic sif1, sidex1, bub1, fl1, sexm1;
    logic sif8, sidex8, bub8, fl8, sexm8;
    logic [4:0] o4, o1, o8;

    int n_tests = 0;
    int n_fail  = 0;
    int exp4 = 0, exp1 = 0, exp8 = 0;

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] cnt4, cnt1, cnt8;
`endif

    always #5 clk = ~clk;

    assign o4 = {sif4, sidex4, bub4, fl4, sexm4};
    assign o1 = {sif1, sidex1, bub1, fl1, sexm1};
    assign o8 = {sif8, sidex8, bub8, fl8, sexm8};

    hazard_ctrl #(.REG_W(4), .DMEM_LAT(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .srcA_ID(srcA), .srcAUsed_ID(aUsed), .srcB_ID(srcB), .srcBUsed_ID(bUsed),
        .destReg_EX(dest), .writeReg_EX(wr), .memRead_EX(rd),
        .memAccess_MEM(m4), .flush(fl),
        .stall_IF(sif4), .stall_ID_EX(sidex4), .bubble_ID_EX(bub4),
        .flush_IF_ID(fl4), .stall_EX_MEM(sexm4)
`ifdef HAZARD_STALL_CNT_EN
        , .stallCycles(cnt4)
`endif
    );

    hazard_ctrl #(.REG_W(4), .DMEM_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .srcA_ID(srcA), .srcAUsed_ID(aUsed), .srcB_ID(srcB), .srcBUsed_ID(bUsed),
        .destReg_EX(dest), .writeReg_EX(wr), .memRead_EX(rd),
        .memAccess_MEM(m1), .flush(fl),
        .stall_IF(sif1), .stall_ID_EX(sidex1), .bubble_ID_EX(bub1),
        .flush_IF_ID(fl1), .stall_EX_MEM(sexm1)
`ifdef HAZARD_STALL_CNT_EN
        , .stallCycles(cnt1)
`endif
    );

    hazard_ctrl #(.REG_W(4), .DMEM_LAT(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .srcA_ID(srcA), .srcAUsed_ID(aUsed), .srcB_ID(srcB), .srcBUsed_ID(bUsed),
        .destReg_EX(dest), .writeReg_EX(wr), .memRead_EX(rd),
        .memAccess_MEM(m8), .flush(fl),
        .stall_IF(sif8), .stall_ID_EX(sidex8), .bubble_ID_EX(bub8),
        .flush_IF_ID(fl8), .stall_EX_MEM(sexm8)
`ifdef HAZARD_STALL_CNT_EN
        , .stallCycles(cnt8)
`endif
    );

    typedef struct {
        logic [3:0] a;
        logic       au;
        logic [3:0] b;
        logic       bu;
        logic [3:0] d;
        logic       wr;
        logic       rd;
        logic       fl;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic setin(input logic [3:0] a, input logic au, input logic [3:0] b, input logic bu,
                         input logic [3:0] d, input logic w, input logic r, input logic f,
                         input logic x4, input logic x1, input logic x8);
        srcA = a; aUsed = au; srcB = b; bUsed = bu; dest = d;
        wr = w; rd = r; fl = f; m4 = x4; m1 = x1; m8 = x8;
    endtask

    // Checks the combinational outputs of all three instances ahead of the next rising edge
    // and advances the expected stall counts for that edge.
    task automatic step(input string nm, input logic [4:0] e4, input logic [4:0] e1, input logic [4:0] e8);
        #2;
        chk({nm, "_L4"}, {11'd0, o4}, {11'd0, e4});
        chk({nm, "_L1"}, {11'd0, o1}, {11'd0, e1});
        chk({nm, "_L8"}, {11'd0, o8}, {11'd0, e8});
        if (!rst_n) begin
            exp4 = 0; exp1 = 0; exp8 = 0;
        end else begin
            if (e4[4]) exp4++;
            if (e1[4]) exp1++;
            if (e8[4]) exp8++;
        end
    endtask

    task automatic chk_counts(input string nm);
`ifdef HAZARD_STALL_CNT_EN
        chk({nm, "_cnt4"}, cnt4, 16'(exp4));
        chk({nm, "_cnt1"}, cnt1, 16'(exp1));
        chk({nm, "_cnt8"}, cnt8, 16'(exp8));
`endif
    endtask

    initial begin
        tbl[0]  = '{a:4'd3,  au:1'b1, b:4'd0,  bu:1'b0, d:4'd3,  wr:1'b1, rd:1'b1, fl:1'b0, exp:LU};
        tbl[1]  = '{a:4'd3,  au:1'b0, b:4'd0,  bu:1'b0, d:4'd3,  wr:1'b1, rd:1'b1, fl:1'b0, exp:NONE};
        tbl[2]  = '{a:4'd0,  au:1'b0, b:4'd5,  bu:1'b1, d:4'd5,  wr:1'b1, rd:1'b1, fl:1'b0, exp:LU};
        tbl[3]  = '{a:4'd1,  au:1'b1, b:4'd5,  bu:1'b0, d:4'd5,  wr:1'b1, rd:1'b1, fl:1'b0, exp:NONE};
        tbl[4]  = '{a:4'd3,  au:1'b1, b:4'd0,  bu:1'b0, d:4'd3,  wr:1'b0, rd:1'b1, fl:1'b0, exp:NONE};
        tbl[5]  = '{a:4'd3,  au:1'b1, b:4'd0,  bu:1'b0, d:4'd3,  wr:1'b1, rd:1'b0, fl:1'b0, exp:NONE};
        tbl[6]  = '{a:4'd0,  au:1'b1, b:4'd9,  bu:1'b0, d:4'd0,  wr:1'b1, rd:1'b1, fl:1'b0, exp:LU};
        tbl[7]  = '{a:4'd3,  au:1'b1, b:4'd0,  bu:1'b0, d:4'd3,  wr:1'b1, rd:1'b1, fl:1'b1, exp:FL};
        tbl[8]  = '{a:4'd1,  au:1'b0, b:4'd2,  bu:1'b0, d:4'd7,  wr:1'b0, rd:1'b0, fl:1'b1, exp:FL};
        tbl[9]  = '{a:4'd2,  au:1'b1, b:4'd4,  bu:1'b1, d:4'd6,  wr:1'b1, rd:1'b1, fl:1'b0, exp:NONE};
        tbl[10] = '{a:4'd14, au:1'b1, b:4'd15, bu:1'b1, d:4'd15, wr:1'b1, rd:1'b1, fl:1'b0, exp:LU};

        // Reset: outputs forced low even with hazards and accesses presented.
        rst_n = 1'b0;
        setin(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk); step("rst0", NONE, NONE, NONE);
        @(negedge clk); step("rst1", NONE, NONE, NONE);
        @(negedge clk); rst_n = 1'b1;
        setin(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_counts("after_rst");
        step("idle", NONE, NONE, NONE);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            setin(tbl[i].a, tbl[i].au, tbl[i].b, tbl[i].bu, tbl[i].d, tbl[i].wr, tbl[i].rd, tbl[i].fl,
                  1'b0, 1'b0, 1'b0);
            step($sformatf("vec%0d", i), tbl[i].exp, tbl[i].exp, tbl[i].exp);
        end

        // Load-use lasts one cycle: the next cycle EX holds the bubble.
        @(negedge clk); setin(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_c0", LU, LU, LU);
        @(negedge clk); setin(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_c1", NONE, NONE, NONE);
        chk_counts("after_lu");

        // Memory wait with the access held in MEM, then a back-to-back access.
        @(negedge clk); setin(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("mw_c0", MS, NONE, NONE);
        @(negedge clk); step("mw_c1", MS, NONE, NONE);
        @(negedge clk); step("mw_c2", MS, NONE, NONE);
        @(negedge clk); step("mw_rel", NONE, NONE, NONE);
        @(negedge clk); step("b2b_c0", MS, NONE, NONE);
        @(negedge clk); m4 = 1'b0; m1 = 1'b0;
        step("b2b_c1", MS, NONE, NONE);
        @(negedge clk); step("b2b_c2", MS, NONE, NONE);
        @(negedge clk); step("b2b_rel", NONE, NONE, NONE);
        @(negedge clk); step("b2b_idle", NONE, NONE, NONE);
        chk_counts("after_mw");

        // Wait dominates flush/load-use; release cycle lets flush through.
        @(negedge clk); setin(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step("dom_c0", MS, FL, FL);
        @(negedge clk); m4 = 1'b0;
        step("dom_c1", MS, FL, FL);
        @(negedge clk); step("dom_c2", MS, FL, FL);
        @(negedge clk); step("dom_rel", FL, FL, FL);
        @(negedge clk); fl = 1'b0;
        step("dom_lu", LU, LU, LU);
        @(negedge clk); setin(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("dom_idle", NONE, NONE, NONE);
        chk_counts("after_dom");

        // Reset in the middle of a DMEM_LAT=8 wait.
        @(negedge clk); m8 = 1'b1;
        step("rw_c0", NONE, NONE, MS);
        @(negedge clk); m8 = 1'b0; rst_n = 1'b0; fl = 1'b1;
        step("rw_rst", NONE, NONE, NONE);
        @(negedge clk); rst_n = 1'b1; fl = 1'b0;
        step("rw_c2", NONE, NONE, NONE);
        @(negedge clk); step("rw_c3", NONE, NONE, NONE);
        chk_counts("after_rw");

`ifdef HAZARD_STALL_CNT_EN
        // Saturation: a permanent load-use hazard stalls every cycle.
        @(negedge clk); setin(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("sat_c0", LU, LU, LU);
        for (int i = 0; i < 70000; i++) @(negedge clk);
        #2;
        chk("sat_cnt4", cnt4, 16'hFFFF);
        chk("sat_cnt1", cnt1, 16'hFFFF);
        for (int i = 0; i < 3; i++) @(negedge clk);
        #2;
        chk("sat_hold4", cnt4, 16'hFFFF);
        chk("sat_hold8", cnt8, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
